// File: rtl/lbp_stream.sv
// rtl/lbp_stream.sv - streaming 3x3 local binary pattern on a raster pixel stream.
// Optional lbp_uniform output is enabled by defining LBP_UNIFORM_EN.
module lbp_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic                  lbp_valid,
  output logic [7:0]            lbp_out,
`ifdef LBP_UNIFORM_EN
  output logic                  lbp_eof,
  output logic                  lbp_uniform
`else
  output logic                  lbp_eof
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;

  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];

  logic [DATA_WIDTH-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic [DATA_WIDTH-1:0] win_thresh;
  logic                  win_valid, win_eof;

  logic [DATA_WIDTH:0]   ref_sum;
  logic [7:0]            code;

  // sof relocates the accepted pixel to (0,0), abandoning any partial frame
  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Pixel storage needs no reset: two full rows are rewritten before any window is valid
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= pix_in;
      w0 <= w1;  w1 <= w2;  w2 <= lb2[cur_col];
      w3 <= w4;  w4 <= w5;  w5 <= lb1[cur_col];
      w6 <= w7;  w7 <= w8;  w8 <= pix_in;
      win_thresh <= thresh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
    end else begin
      win_valid <= pix_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      win_eof   <= pix_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

  function automatic logic ge(input logic [DATA_WIDTH-1:0] p, input logic [DATA_WIDTH:0] s);
    return {1'b0, p} >= s;
  endfunction

  // Sum kept one bit wider so a large offset never wraps into a small reference
  always_comb begin
    ref_sum = {1'b0, w4} + {1'b0, win_thresh};
    code    = {ge(w8, ref_sum), ge(w7, ref_sum), ge(w6, ref_sum), ge(w3, ref_sum),
               ge(w0, ref_sum), ge(w1, ref_sum), ge(w2, ref_sum), ge(w5, ref_sum)};
  end

`ifdef LBP_UNIFORM_EN
  logic [7:0] code_rot;
  logic [3:0] trans_cnt;
  logic       uniform;

  always_comb begin
    code_rot  = {code[0], code[7:1]};
    trans_cnt = 4'($countones(code ^ code_rot));
    uniform   = (trans_cnt <= 4'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbp_uniform <= 1'b0;
    end else if (win_valid) begin
      lbp_uniform <= uniform;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbp_valid <= 1'b0;
      lbp_eof   <= 1'b0;
      lbp_out   <= 8'h00;
    end else begin
      lbp_valid <= win_valid;
      lbp_eof   <= win_valid && win_eof;
      if (win_valid) begin
        lbp_out <= code;
      end
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// tb/tb_lbp_stream.sv - self-checking bench for lbp_stream against an image-level LBP model.
module tb_lbp_stream;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic [DW-1:0] thresh = '0;
  logic          lbp_valid;
  logic [7:0]    lbp_out;
  logic          lbp_eof;
`ifdef LBP_UNIFORM_EN
  logic          lbp_uniform;
`endif

  always #5 clk = ~clk;

  lbp_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .thresh    (thresh),
    .lbp_valid (lbp_valid),
    .lbp_out   (lbp_out),
`ifdef LBP_UNIFORM_EN
    .lbp_eof   (lbp_eof),
    .lbp_uniform (lbp_uniform)
`else
    .lbp_eof   (lbp_eof)
`endif
  );

  typedef struct {
    int         due;
    logic [7:0] code;
    logic       eof;
    logic       uni;
  } exp_t;

  exp_t       expq[$];
  int         img[H][W];
  int         mrow, mcol, cyc;
  int         checks, errors;
  logic [7:0] last_out;
  int         n_out, n_eof, eof_at, first_out_cyc, const_exp, frame_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Neighbour offsets (rows back, cols back) from the newest pixel, indexed by output bit
  function automatic logic [7:0] lbp_ref(input int r, input int c, input int th);
    int dr[8];
    int dc[8];
    int ctr;
    logic [7:0] code;
    dr  = '{1, 2, 2, 2, 1, 0, 0, 0};
    dc  = '{0, 0, 1, 2, 2, 2, 1, 0};
    ctr = img[r-1][c-1];
    for (int b = 0; b < 8; b++) code[b] = (img[r-dr[b]][c-dc[b]] >= ctr + th);
    return code;
  endfunction

  function automatic logic uniform_ref(input logic [7:0] code);
    int t;
    t = 0;
    for (int i = 0; i < 8; i++) if (code[i] != code[(i+1) % 8]) t++;
    return t <= 2;
  endfunction

  task automatic stats_reset();
    n_out = 0; n_eof = 0; eof_at = -1; first_out_cyc = -1;
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] p, input logic [7:0] th);
    exp_t e;
    int r, c;
    sof = s; pix_valid = v; pix_in = p; thresh = th;
    @(negedge clk);
    if (lbp_valid === 1'b1) begin
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    if (lbp_eof === 1'b1) begin
      n_eof++;
      eof_at = n_out;
    end
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("valid", 32'(lbp_valid), 32'd1);
      chk("code", 32'(lbp_out), 32'(e.code));
      chk("eof", 32'(lbp_eof), 32'(e.eof));
`ifdef LBP_UNIFORM_EN
      chk("uniform", 32'(lbp_uniform), 32'(e.uni));
`endif
      if (const_exp >= 0) chk("frame_const", 32'(lbp_out), 32'(const_exp));
      last_out = e.code;
    end else begin
      chk("idle_valid", 32'(lbp_valid), 32'd0);
      chk("idle_eof", 32'(lbp_eof), 32'd0);
      chk("hold_out", 32'(lbp_out), 32'(last_out));
    end
    if (v) begin
      r = s ? 0 : mrow;
      c = s ? 0 : mcol;
      img[r][c] = int'(p);
      if (r >= 2 && c >= 2) begin
        e.due  = cyc + 2;
        e.code = lbp_ref(r, c, int'(th));
        e.eof  = (r == H-1 && c == W-1);
        e.uni  = uniform_ref(e.code);
        expq.push_back(e);
      end
      c++;
      if (c == W) begin
        c = 0;
        r++;
        if (r == H) r = 0;
      end
      mrow = r; mcol = c;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_pixels(input int kind, input int th_fixed, input int gap_pct,
                             input bit use_sof, input int npix);
    logic [7:0] p, th;
    int gaps;
    for (int i = 0; i < npix; i++) begin
      gaps = 0;
      while (gap_pct > 0 && gaps < 8 && $urandom_range(0, 99) < gap_pct) begin
        step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
        gaps++;
      end
      case (kind)
        0:       p = 8'd50;
        1:       p = 8'((i % W) * 10);
        default: p = 8'($urandom_range(0, 255));
      endcase
      th = (th_fixed >= 0) ? 8'(th_fixed) : 8'($urandom_range(0, 40));
      step(1'b1, use_sof && (i == 0), p, th);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_outputs"}, 32'(n_out), 32'd24);
    chk({tag, "_eof_count"}, 32'(n_eof), 32'd1);
    chk({tag, "_eof_on_last"}, 32'(eof_at), 32'd24);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; mrow = 0; mcol = 0;
    last_out = 8'h00; const_exp = -1;
    stats_reset();

    #12;
    chk("reset_valid", 32'(lbp_valid), 32'd0);
    chk("reset_out", 32'(lbp_out), 32'h00);
    chk("reset_eof", 32'(lbp_eof), 32'd0);
`ifdef LBP_UNIFORM_EN
    chk("reset_uniform", 32'(lbp_uniform), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Flat frame: every neighbour equals the centre
    const_exp = 8'hFF; stats_reset();
    send_pixels(0, 0, 0, 1'b1, W*H); flush(); check_frame("flat_t0");
    const_exp = 8'h00; stats_reset();
    send_pixels(0, 1, 0, 1'b1, W*H); flush(); check_frame("flat_t1");

    // Horizontal ramp, then an offset large enough to overflow the pixel range
    const_exp = 8'hC7; stats_reset();
    send_pixels(1, 0, 0, 1'b1, W*H); flush(); check_frame("ramp_t0");
    const_exp = 8'h00; stats_reset();
    send_pixels(1, 250, 0, 1'b1, W*H); flush(); check_frame("ramp_t250");

    const_exp = 8'hC7; stats_reset();
    send_pixels(1, 0, 50, 1'b1, W*H); flush(); check_frame("ramp_gaps");
    const_exp = -1;

    // Frame abandoned by sof at (3,4)
    stats_reset();
    send_pixels(2, -1, 0, 1'b1, 3*W + 4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("partial_eof_count", 32'(n_eof), 32'd0);
    chk("partial_outputs", 32'(n_out), 32'd8);
    stats_reset();
    send_pixels(2, -1, 0, 1'b1, W*H); flush(); check_frame("after_sof");

    stats_reset();
    send_pixels(2, -1, 30, 1'b1, W*H); flush(); check_frame("random_gaps");

    // Asynchronous reset after accepting (4,2)
    stats_reset();
    send_pixels(2, -1, 0, 1'b1, 4*W + 3);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(lbp_valid), 32'd0);
    chk("async_out", 32'(lbp_out), 32'h00);
    chk("async_eof", 32'(lbp_eof), 32'd0);
    expq.delete();
    last_out = 8'h00; mrow = 0; mcol = 0;
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    stats_reset();
    frame_start = cyc;
    send_pixels(2, -1, 0, 1'b0, W*H); flush(); check_frame("post_reset");
    chk("post_reset_first_latency", 32'(first_out_cyc - frame_start), 32'(2*W + 2 + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
